// File: rtl/ysyx_22050078_ctrl_fsm_if.sv
// Handshake and status bundle between the control FSM and the fetch/data/datapath side.
// Master is the sequencer; slave is the memory and datapath environment.
interface ysyx_22050078_ctrl_fsm_if #(
    parameter int PC_WIDTH   = 64,
    parameter int INST_WIDTH = 32
);
    logic                  imem_req;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic                  imem_ack;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic [INST_WIDTH-1:0] inst_out;
    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   exu_next_pc;
    logic                  dmem_req;
    logic                  dmem_we;
    logic                  dmem_ack;
    logic                  rf_wen;
    logic                  halt;
    logic [2:0]            state;
    logic [63:0]           cycle_cnt;
    logic [63:0]           instret_cnt;

    modport master (
        output imem_req, imem_addr, inst_out, pc, dmem_req, dmem_we,
               rf_wen, halt, state, cycle_cnt, instret_cnt,
        input  imem_ack, imem_rdata, exu_next_pc, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, inst_out, pc, dmem_req, dmem_we,
               rf_wen, halt, state, cycle_cnt, instret_cnt,
        output imem_ack, imem_rdata, exu_next_pc, dmem_ack
    );
endinterface

// File: rtl/ysyx_22050078_ctrl_fsm.sv
// Multi-cycle sequencer owning PC and IR: fetch, decode, exec, optional mem, write-back; halts on ebreak.
// Latency: 4 cycles per instruction, 5 with a memory access, plus one per imem/dmem wait cycle.
// Backpressure: FETCH and MEM hold their request until ack. YSYX_22050078_PERF_CNT_EN adds perf counters.
module ysyx_22050078_ctrl_fsm #(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22050078_ctrl_fsm_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [6:0]            OP_LOAD   = 7'b0000011;
    localparam logic [6:0]            OP_STORE  = 7'b0100011;
    localparam logic [6:0]            OP_BRANCH = 7'b1100011;
    localparam logic [INST_WIDTH-1:0] EBREAK    = INST_WIDTH'(32'h0010_0073);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_npc;
    logic [INST_WIDTH-1:0] r_ir;
    logic                  r_imem_req;
    logic                  r_dmem_req;
    logic                  r_dmem_we;
    logic                  r_rf_wen;
    logic                  r_halt;

    logic                  w_ir_ld;
    logic                  w_npc_ld;
    logic                  w_pc_ld;
    logic [6:0]            w_opcode;
    logic [4:0]            w_rd;
    logic                  w_is_store;
    logic                  w_is_mem;
    logic                  w_writes_rf;
    logic                  w_imem_req_nxt;
    logic                  w_dmem_req_nxt;
    logic                  w_dmem_we_nxt;
    logic                  w_rf_wen_nxt;
    logic                  w_halt_nxt;

    assign w_opcode    = r_ir[6:0];
    assign w_rd        = r_ir[11:7];
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_mem    = (w_opcode == OP_LOAD) || w_is_store;
    assign w_writes_rf = !w_is_store && (w_opcode != OP_BRANCH) && (w_rd != 5'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_ir_ld     = 1'b0;
        w_npc_ld    = 1'b0;
        w_pc_ld     = 1'b0;
        unique case (r_state)
            ST_IDLE:   w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    w_ir_ld     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: w_state_nxt = (r_ir == EBREAK) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                w_npc_ld    = 1'b1;
                w_state_nxt = w_is_mem ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                w_pc_ld     = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_HALT:   w_state_nxt = ST_HALT;
            default:   w_state_nxt = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so they register in step with it.
        w_imem_req_nxt = (w_state_nxt == ST_FETCH);
        w_dmem_req_nxt = (w_state_nxt == ST_MEM);
        w_dmem_we_nxt  = (w_state_nxt == ST_MEM) && w_is_store;
        w_rf_wen_nxt   = (w_state_nxt == ST_WB) && w_writes_rf;
        w_halt_nxt     = (w_state_nxt == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_npc      <= '0;
            r_ir       <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_rf_wen   <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_imem_req <= w_imem_req_nxt;
            r_dmem_req <= w_dmem_req_nxt;
            r_dmem_we  <= w_dmem_we_nxt;
            r_rf_wen   <= w_rf_wen_nxt;
            r_halt     <= w_halt_nxt;
            if (w_ir_ld) begin
                r_ir <= bus.imem_rdata;
            end
            if (w_npc_ld) begin
                r_npc <= bus.exu_next_pc;
            end
            if (w_pc_ld) begin
                r_pc <= r_npc;
            end
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.inst_out  = r_ir;
    assign bus.pc        = r_pc;
    assign bus.dmem_req  = r_dmem_req;
    assign bus.dmem_we   = r_dmem_we;
    assign bus.rf_wen    = r_rf_wen;
    assign bus.halt      = r_halt;
    assign bus.state     = r_state;

`ifdef YSYX_22050078_PERF_CNT_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;

    // An ebreak never reaches WB, so it is not counted as retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 64'd1;
            if (r_state == ST_WB) begin
                r_instret_cnt <= r_instret_cnt + 64'd1;
            end
        end
    end

    assign bus.cycle_cnt   = r_cycle_cnt;
    assign bus.instret_cnt = r_instret_cnt;
`else
    assign bus.cycle_cnt   = '0;
    assign bus.instret_cnt = '0;
`endif

    a_imem_req_in_fetch: assert property (@(posedge clk) disable iff (rst)
        r_imem_req == (r_state == ST_FETCH));
    a_dmem_req_in_mem: assert property (@(posedge clk) disable iff (rst)
        r_dmem_req == (r_state == ST_MEM));
    a_rf_wen_in_wb: assert property (@(posedge clk) disable iff (rst)
        r_rf_wen |-> (r_state == ST_WB));
    a_halt_sticky: assert property (@(posedge clk) disable iff (rst)
        r_halt |=> r_halt);

endmodule

// File: tb/tb_ysyx_22050078_ctrl_fsm.sv
// Vector-table bench for the control FSM: per-instruction scoreboard plus halt and mid-instruction reset sequences.
module tb_ysyx_22050078_ctrl_fsm;

    localparam logic [63:0] RST_PC   = 64'h8000_0000;
    localparam logic [31:0] EBRK     = 32'h0010_0073;
    localparam logic [2:0]  S_IDLE   = 3'd0;
    localparam logic [2:0]  S_FETCH  = 3'd1;
    localparam logic [2:0]  S_DECODE = 3'd2;
    localparam logic [2:0]  S_MEM    = 3'd4;
    localparam logic [2:0]  S_WB     = 3'd5;
    localparam logic [2:0]  S_HALT   = 3'd6;
    localparam int          NV       = 6;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] npc;
        int          iw;
        int          dw;
        logic        store;
        int          rf_cnt;
        int          cyc;
    } vec_t;

    typedef struct {
        int          rf_cnt;
        int          rf_at;
        logic [63:0] pc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sbq[$];
    vec_t vecs[NV];

    always #5 clk = ~clk;

    ysyx_22050078_ctrl_fsm_if #(.PC_WIDTH(64), .INST_WIDTH(32)) bus ();

    ysyx_22050078_ctrl_fsm #(
        .PC_WIDTH  (64),
        .INST_WIDTH(32),
        .RESET_PC  (64'h8000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Runs one instruction from its first FETCH cycle until the next FETCH; sampling is #1 after each edge.
    task automatic run_inst(input vec_t v, input logic [63:0] cur_pc);
        int   cyc = 0, fcnt = 0, mcnt = 0, rf_cnt = 0, rf_at = -1;
        int   mem_bad = 0, pc_bad = 0, ir_bad = 0;
        bit   left = 0;
        exp_t e, o;
        e.rf_cnt = v.rf_cnt;
        e.rf_at  = (v.rf_cnt != 0) ? v.cyc - 1 : -1;
        e.pc     = v.npc;
        e.cyc    = v.cyc;
        sbq.push_back(e);
        bus.exu_next_pc = v.npc;
        bus.imem_rdata  = v.inst;
        while (cyc < 60) begin
            if (bus.state == S_FETCH && left) break;
            if (bus.state == S_FETCH) begin
                if (bus.imem_addr !== cur_pc || bus.imem_req !== 1'b1) pc_bad++;
                bus.imem_ack = (fcnt == v.iw);
                fcnt++;
            end else begin
                left = 1;
                bus.imem_ack = 1'($urandom);
                if (bus.pc !== cur_pc) pc_bad++;
            end
            if (bus.state == S_DECODE && bus.inst_out !== v.inst) ir_bad++;
            if (bus.state == S_MEM) begin
                if (bus.dmem_req !== 1'b1 || bus.dmem_we !== v.store) mem_bad++;
                bus.dmem_ack = (mcnt == v.dw);
                mcnt++;
            end else begin
                bus.dmem_ack = 1'($urandom);
            end
            if (bus.rf_wen === 1'b1) begin
                rf_cnt++;
                rf_at = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 60) begin
            bad++;
            total++;
            $display("FAIL timeout inst=%h actual=%0d required=<60", v.inst, cyc);
        end
        o.rf_cnt = rf_cnt;
        o.rf_at  = rf_at;
        o.pc     = bus.pc;
        o.cyc    = cyc;
        if (sbq.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sbq.pop_front();
            check($sformatf("rf_cnt_%h", v.inst), 64'(o.rf_cnt), 64'(e.rf_cnt));
            check($sformatf("rf_at_%h", v.inst), 64'(o.rf_at), 64'(e.rf_at));
            check($sformatf("pc_next_%h", v.inst), o.pc, e.pc);
            check($sformatf("cycles_%h", v.inst), 64'(o.cyc), 64'(e.cyc));
        end
        check($sformatf("pc_hold_%h", v.inst), 64'(pc_bad), 64'd0);
        check($sformatf("ir_%h", v.inst), 64'(ir_bad), 64'd0);
        check($sformatf("mem_cycles_%h", v.inst), 64'(mcnt), 64'(v.dw + ((v.inst[6:0] == 7'b0000011 || v.store) ? 1 : 0)));
        check($sformatf("mem_strobe_%h", v.inst), 64'(mem_bad), 64'd0);
    endtask

    initial begin
        logic [63:0] cur_pc;
        logic [63:0] pc_h;
        int          hbad, wait_cnt;

        vecs[0] = '{32'h0050_0093, 64'h8000_0004, 0, 0, 1'b0, 1, 4};  // addi x1,x0,5
        vecs[1] = '{32'h0011_3023, 64'h8000_0008, 2, 2, 1'b1, 0, 9};  // sd x1,0(x2), slow fetch and memory
        vecs[2] = '{32'h0010_0013, 64'h8000_000c, 0, 0, 1'b0, 0, 4};  // addi x0,x0,1
        vecs[3] = '{32'h0001_3283, 64'h8000_0010, 1, 0, 1'b0, 1, 6};  // ld x5,0(x2)
        vecs[4] = '{32'h0000_0463, 64'h8000_0018, 0, 0, 1'b0, 0, 4};  // beq x0,x0,8
        vecs[5] = '{32'h0000_00ff, 64'h8000_001c, 0, 0, 1'b0, 1, 4};  // unknown opcode, rd=x1

        rst             = 1'b1;
        bus.imem_ack    = 1'b1;
        bus.imem_rdata  = '0;
        bus.exu_next_pc = '0;
        bus.dmem_ack    = 1'b0;

        #12;
        check("rst_state", 64'(bus.state), 64'(S_IDLE));
        check("rst_pc", bus.pc, RST_PC);
        check("rst_ir", 64'(bus.inst_out), 64'd0);
        check("rst_imem_req", 64'(bus.imem_req), 64'd0);
        check("rst_dmem", 64'({bus.dmem_req, bus.dmem_we, bus.rf_wen, bus.halt}), 64'd0);
        check("rst_cnt", bus.cycle_cnt | bus.instret_cnt, 64'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_no_req", 64'(bus.imem_req), 64'd0);
        @(posedge clk);
        #1;
        check("first_fetch_state", 64'(bus.state), 64'(S_FETCH));
        check("first_fetch_req", 64'(bus.imem_req), 64'd1);
        check("first_fetch_addr", bus.imem_addr, RST_PC);

        cur_pc = RST_PC;
        for (int i = 0; i < NV; i++) begin
            run_inst(vecs[i], cur_pc);
            cur_pc = vecs[i].npc;
        end

        // ebreak: HALT follows DECODE and is absorbing
        pc_h           = bus.pc;
        bus.imem_rdata = EBRK;
        bus.imem_ack   = 1'b1;
        @(posedge clk);
        #1;
        check("ebrk_decode", 64'(bus.state), 64'(S_DECODE));
        check("ebrk_decode_halt", 64'(bus.halt), 64'd0);
        @(posedge clk);
        #1;
        check("halt_state", 64'(bus.state), 64'(S_HALT));
        check("halt_set", 64'(bus.halt), 64'd1);
`ifdef YSYX_22050078_PERF_CNT_EN
        check("instret_at_halt", bus.instret_cnt, 64'(NV));
`endif
        hbad = 0;
        for (int k = 0; k < 100; k++) begin
            bus.imem_ack    = 1'($urandom);
            bus.dmem_ack    = 1'($urandom);
            bus.imem_rdata  = $urandom;
            bus.exu_next_pc = {$urandom, $urandom};
            @(posedge clk);
            #1;
            if (bus.halt !== 1'b1 || bus.state !== S_HALT || bus.imem_req !== 1'b0 ||
                bus.dmem_req !== 1'b0 || bus.rf_wen !== 1'b0 || bus.pc !== pc_h ||
                bus.inst_out !== EBRK) hbad++;
        end
        check("halt_hold", 64'(hbad), 64'd0);
        check("halt_pc", bus.pc, pc_h);
`ifdef YSYX_22050078_PERF_CNT_EN
        check("instret_after_halt", bus.instret_cnt, 64'(NV));
        check("cycle_cnt_runs", 64'(bus.cycle_cnt > 64'd100), 64'd1);
`else
        check("cnt_tied_zero", bus.cycle_cnt | bus.instret_cnt, 64'd0);
`endif

        // Reset pulse from HALT, then reset again while a store waits in MEM
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("unhalt", 64'(bus.halt), 64'd0);
        bus.imem_ack   = 1'b1;
        bus.dmem_ack   = 1'b0;
        bus.imem_rdata = 32'h0011_3023;
        wait_cnt = 0;
        while (bus.state !== S_MEM && wait_cnt < 20) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        check("reach_mem", 64'(bus.state), 64'(S_MEM));
        check("mem_req_before_rst", 64'(bus.dmem_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dmem_req", 64'(bus.dmem_req), 64'd0);
        check("arst_state", 64'(bus.state), 64'(S_IDLE));
        check("arst_pc", bus.pc, RST_PC);
        @(negedge clk);
        rst = 1'b0;
        bus.dmem_ack = 1'b1;
        #1;
        check("post_rst_idle", 64'(bus.state), 64'(S_IDLE));
        @(posedge clk);
        #1;
        check("post_rst_fetch_req", 64'(bus.imem_req), 64'd1);
        check("post_rst_fetch_addr", bus.imem_addr, RST_PC);
        check("post_rst_no_dmem", 64'(bus.dmem_req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
